// File: rtl/lmul_pkg.sv
// Shared types for the LSTM multiply path: sequencer states and datapath widths.
package lmul_pkg;

    localparam int BF16_W = 16;
    localparam int ACC_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/wx_timeout_ctr.sv
// Counts consecutive not-ready cycles while waiting on the multiplier.
// expired rises on the LIMIT-th enabled cycle since the last clear.
module wx_timeout_ctr #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    assign expired = enable && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/wx_matvec_sched.sv
// Sequences one W*x pass over a single shared multiplier and streams row sums.
// W is walked row-major; each row's products are wrap-added into a 32-bit sum.
module wx_matvec_sched
    import lmul_pkg::*;
#(
    parameter int ROWS        = 10,
    parameter int COLS        = 10,
    parameter int MUL_TIMEOUT = 64,
    parameter int AW          = $clog2(ROWS * COLS),
    parameter int XW          = $clog2(COLS),
    parameter int RW          = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AW-1:0]     w_addr,
    input  logic [BF16_W-1:0] w_data,
    output logic [XW-1:0]     x_addr,
    input  logic [BF16_W-1:0] x_data,
    output logic              mul_start,
    output logic [BF16_W-1:0] mul_a,
    output logic [BF16_W-1:0] mul_b,
    input  logic              mul_ready,
    input  logic [ACC_W-1:0]  mul_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [RW-1:0]     sum_row,
    output logic [ACC_W-1:0]  sum_data,
    output logic [31:0]       cycle_cnt
);

    function automatic logic [ACC_W-1:0] wrap_add(input logic [ACC_W-1:0] a,
                                                  input logic [ACC_W-1:0] b);
        return a + b;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t           state;
    logic [RW-1:0]    row;
    logic [XW-1:0]    col;
    logic [AW-1:0]    row_base;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic             col_last;
    logic             row_last;
    logic             tmo_clear;
    logic             tmo_enable;
    logic             tmo_expired;

    assign acc_nxt    = wrap_add(acc, mul_out);
    assign col_last   = (col == XW'(COLS - 1));
    assign row_last   = (row == RW'(ROWS - 1));
    assign tmo_clear  = (state == S_ISSUE);
    assign tmo_enable = (state == S_WAIT) && !mul_ready;

    wx_timeout_ctr #(
        .LIMIT (MUL_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // Every output is a register; each is loaded on the edge that enters the
    // state in which it must be visible, so w/x addresses are valid in FETCH
    // and mul_start is high during ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            row       <= '0;
            col       <= '0;
            row_base  <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            w_addr    <= '0;
            x_addr    <= '0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            sum_valid <= 1'b0;
            sum_row   <= '0;
            sum_data  <= '0;
            cycle_cnt <= '0;
        end else begin
            mul_start <= 1'b0;
            done      <= 1'b0;
            if (state != S_IDLE) begin
                cycle_cnt <= sat_inc(cycle_cnt);
            end

            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        row       <= '0;
                        col       <= '0;
                        row_base  <= '0;
                        acc       <= '0;
                        err       <= 1'b0;
                        cycle_cnt <= '0;
                        busy      <= 1'b1;
                        w_addr    <= '0;
                        x_addr    <= '0;
                        state     <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    mul_start <= 1'b1;
                    state     <= S_ISSUE;
                end

                S_ISSUE: begin
                    mul_a <= w_data;
                    mul_b <= x_data;
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (mul_ready) begin
                        acc <= acc_nxt;
                        if (col_last) begin
                            col       <= '0;
                            sum_valid <= 1'b1;
                            sum_row   <= row;
                            sum_data  <= acc_nxt;
                            state     <= S_EMIT;
                        end else begin
                            col    <= col + XW'(1);
                            w_addr <= row_base + AW'(col) + AW'(1);
                            x_addr <= col + XW'(1);
                            state  <= S_FETCH;
                        end
                    end else if (tmo_expired) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                // Backpressure may hold EMIT indefinitely; outputs stay frozen.
                S_EMIT: begin
                    if (sum_ready) begin
                        sum_valid <= 1'b0;
                        acc       <= '0;
                        if (row_last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            row      <= row + RW'(1);
                            row_base <= row_base + AW'(COLS);
                            w_addr   <= row_base + AW'(COLS);
                            x_addr   <= '0;
                            state    <= S_FETCH;
                        end
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wx_matvec_sched.sv
// Directed bench for wx_matvec_sched with a latency-3 stub multiplier and sync-read memories.
module tb_wx_matvec_sched;

    localparam int ROWS = 10;
    localparam int COLS = 10;
    localparam int MUL_TIMEOUT = 64;
    localparam int AW = $clog2(ROWS * COLS);
    localparam int XW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_start = 1'b0;
    logic          busy, done, err;
    logic [AW-1:0] w_addr;
    logic [15:0]   w_data;
    logic [XW-1:0] x_addr;
    logic [15:0]   x_data;
    logic          mul_start;
    logic [15:0]   mul_a, mul_b;
    logic          mul_ready;
    logic [31:0]   mul_out;
    logic          sum_valid;
    logic          sum_ready = 1'b1;
    logic [RW-1:0] sum_row;
    logic [31:0]   sum_data;
    logic [31:0]   cycle_cnt;

    int checks = 0;
    int passed = 0;

    logic [15:0] wmem [0:127];
    logic [15:0] xmem [0:15];
    int          lat_cnt;
    logic        never_ready = 1'b0;
    logic        wrap_mode = 1'b0;

    logic [RW-1:0] q_row [$];
    logic [31:0]   q_data [$];
    int            done_cnt = 0;
    int            start_cnt = 0;
    int            sv_cnt = 0;

    wx_matvec_sched #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .MUL_TIMEOUT (MUL_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_start (cmd_start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .x_addr    (x_addr),
        .x_data    (x_data),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_ready (mul_ready),
        .mul_out   (mul_out),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .sum_row   (sum_row),
        .sum_data  (sum_data),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_data <= wmem[w_addr];
        x_data <= xmem[x_addr];
    end

    // Stub multiplier: result valid in the 3rd cycle after the start cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) lat_cnt <= 0;
        else if (mul_start) lat_cnt <= 3;
        else if (lat_cnt > 0) lat_cnt <= lat_cnt - 1;
    end
    assign mul_ready = !never_ready && (lat_cnt == 1);
    assign mul_out   = wrap_mode ? {mul_a, mul_b} : ({16'h0, mul_a} * {16'h0, mul_b});

    always @(negedge clk) begin
        if (!rst) begin
            if (sum_valid) sv_cnt++;
            if (sum_valid && sum_ready) begin
                q_row.push_back(sum_row);
                q_data.push_back(sum_data);
            end
            if (done) done_cnt++;
            if (mul_start) start_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_pass();
        cmd_start = 1'b1;
        step(1);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic fill_unit();
        for (int i = 0; i < 128; i++) wmem[i] = 16'h0001;
        for (int i = 0; i < 16; i++) xmem[i] = 16'h0002;
        wrap_mode = 1'b0;
        never_ready = 1'b0;
        sum_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        checks++;
        if ({busy, done, err, mul_start, sum_valid} !== 5'b0)
            $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, err, mul_start, sum_valid});
        else passed++;
        checks++;
        if (cycle_cnt !== 32'd0) $display("FAIL reset_cycle_cnt got=%0d exp=0", cycle_cnt);
        else passed++;
        checks++;
        if ({w_addr, x_addr, mul_a, mul_b, sum_row, sum_data} !== '0)
            $display("FAIL reset_data got=%h exp=0", {w_addr, x_addr, mul_a, mul_b, sum_row, sum_data});
        else passed++;
        rst = 1'b0;
        step(3);
        checks++;
        if ({busy, cycle_cnt} !== '0) $display("FAIL idle_no_start got=%h exp=0", {busy, cycle_cnt});
        else passed++;
    endtask

    task automatic test_basic();
        int q0, d0, s0, bad;
        bit ok;
        fill_unit();
        q0 = q_row.size();
        d0 = done_cnt;
        s0 = start_cnt;
        start_pass();
        checks++;
        if (busy !== 1'b1) $display("FAIL basic_busy_accept got=%b exp=1", busy);
        else passed++;
        wait_done(1000, ok);
        checks++;
        if (!ok || busy !== 1'b1) $display("FAIL basic_done_busy got=%b/%b exp=1/1", ok, busy);
        else passed++;
        step(1);
        checks++;
        if (cycle_cnt !== 32'd511) $display("FAIL basic_cycle_cnt got=%0d exp=511", cycle_cnt);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL basic_busy_after got=%b exp=0", busy);
        else passed++;
        step(3);
        checks++;
        if (done_cnt - d0 !== 1) $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0);
        else passed++;
        checks++;
        if (start_cnt - s0 !== 100) $display("FAIL basic_mul_starts got=%0d exp=100", start_cnt - s0);
        else passed++;
        bad = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (q_row.size() <= q0 + i) bad++;
            else if (q_row[q0+i] !== RW'(i) || q_data[q0+i] !== 32'h14) bad++;
        end
        checks++;
        if (bad != 0 || q_row.size() - q0 != ROWS)
            $display("FAIL basic_row_sums bad=%0d got_count=%0d exp_count=10 exp_sum=14", bad, q_row.size() - q0);
        else passed++;
        checks++;
        if (cycle_cnt !== 32'd511 || err !== 1'b0)
            $display("FAIL basic_held got=%0d/%b exp=511/0", cycle_cnt, err);
        else passed++;
    endtask

    task automatic test_backpressure();
        int q0, s1, stable;
        bit ok;
        fill_unit();
        q0 = q_row.size();
        start_pass();
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (q_row.size() - q0 >= 3) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        sum_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sum_valid === 1'b1) break;
            step(1);
        end
        checks++;
        if (!ok || sum_valid !== 1'b1 || sum_row !== RW'(3))
            $display("FAIL bp_row3_valid got=%b/%b/%0d exp=1/1/3", ok, sum_valid, sum_row);
        else passed++;
        s1 = start_cnt;
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (sum_valid === 1'b1 && sum_row === RW'(3) && sum_data === 32'h14) stable++;
        end
        checks++;
        if (stable != 20) $display("FAIL bp_stable got=%0d exp=20", stable);
        else passed++;
        checks++;
        if (start_cnt !== s1) $display("FAIL bp_no_issue got=%0d exp=%0d", start_cnt, s1);
        else passed++;
        sum_ready = 1'b1;
        wait_done(1000, ok);
        step(1);
        checks++;
        if (!ok || q_row.size() - q0 != ROWS) $display("FAIL bp_count got=%0d exp=10", q_row.size() - q0);
        else passed++;
        checks++;
        if (cycle_cnt !== 32'd531) $display("FAIL bp_cycle_cnt got=%0d exp=531", cycle_cnt);
        else passed++;
    endtask

    task automatic test_wrap();
        int q0;
        bit ok;
        for (int i = 0; i < 128; i++) wmem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) xmem[i] = 16'h0000;
        wmem[0] = 16'hFFFF;
        xmem[0] = 16'hFFFF;
        xmem[1] = 16'h0002;
        wrap_mode = 1'b1;
        q0 = q_row.size();
        start_pass();
        wait_done(1000, ok);
        step(1);
        checks++;
        if (!ok || q_row.size() - q0 != ROWS) $display("FAIL wrap_count got=%0d exp=10", q_row.size() - q0);
        else passed++;
        if (q_row.size() - q0 == ROWS) begin
            checks++;
            if (q_data[q0] !== 32'h0000_0001) $display("FAIL wrap_row0 got=%h exp=00000001", q_data[q0]);
            else passed++;
            checks++;
            if (q_data[q0+1] !== 32'h0001_0001 || q_data[q0+9] !== 32'h0001_0001)
                $display("FAIL wrap_rows got=%h/%h exp=00010001", q_data[q0+1], q_data[q0+9]);
            else passed++;
        end
        wrap_mode = 1'b0;
    endtask

    task automatic test_timeout();
        int d0, s0, v0;
        bit ok;
        fill_unit();
        never_ready = 1'b1;
        d0 = done_cnt;
        s0 = start_cnt;
        v0 = sv_cnt;
        start_pass();
        wait_done(300, ok);
        checks++;
        if (!ok || err !== 1'b1) $display("FAIL tmo_err got=%b/%b exp=1/1", ok, err);
        else passed++;
        cmd_start = 1'b1;
        step(1);
        cmd_start = 1'b0;
        checks++;
        if (cycle_cnt !== 32'd67) $display("FAIL tmo_cycle_cnt got=%0d exp=67", cycle_cnt);
        else passed++;
        step(2);
        checks++;
        if (busy !== 1'b0 || err !== 1'b1 || cycle_cnt !== 32'd67)
            $display("FAIL tmo_start_in_done got=%b/%b/%0d exp=0/1/67", busy, err, cycle_cnt);
        else passed++;
        checks++;
        if (done_cnt - d0 != 1 || start_cnt - s0 != 1 || sv_cnt != v0)
            $display("FAIL tmo_counts got=%0d/%0d/%0d exp=1/1/0", done_cnt - d0, start_cnt - s0, sv_cnt - v0);
        else passed++;
        never_ready = 1'b0;
        start_pass();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) $display("FAIL tmo_err_clear got=%b/%b exp=0/1", err, busy);
        else passed++;
        wait_done(1000, ok);
        step(1);
        checks++;
        if (!ok || err !== 1'b0) $display("FAIL tmo_rerun got=%b/%b exp=1/0", ok, err);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int q0, d0;
        logic [31:0] c0;
        bit ok;
        fill_unit();
        q0 = q_row.size();
        start_pass();
        for (int i = 0; i < 1000; i++) begin
            if (q_row.size() - q0 >= 2) break;
            step(1);
        end
        c0 = cycle_cnt;
        cmd_start = 1'b1;
        step(1);
        cmd_start = 1'b0;
        checks++;
        if (cycle_cnt !== c0 + 32'd1 || busy !== 1'b1)
            $display("FAIL busy_start_ignored got=%0d/%b exp=%0d/1", cycle_cnt, busy, c0 + 32'd1);
        else passed++;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (q_row.size() - q0 >= 5) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        step(2);
        checks++;
        if (!ok || busy !== 1'b1 || mul_start !== 1'b0 || sum_valid !== 1'b0)
            $display("FAIL mid_wait_reach got=%b/%b/%b/%b exp=1/1/0/0", ok, busy, mul_start, sum_valid);
        else passed++;
        d0 = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, w_addr, x_addr, mul_start, mul_a, mul_b,
             sum_valid, sum_row, sum_data, cycle_cnt} !== '0)
            $display("FAIL mid_reset_outputs got=%h exp=0", {busy, done, err, w_addr, x_addr, mul_start,
                     mul_a, mul_b, sum_valid, sum_row, sum_data, cycle_cnt});
        else passed++;
        step(2);
        rst = 1'b0;
        step(5);
        checks++;
        if (busy !== 1'b0 || done_cnt != d0 || cycle_cnt !== 32'd0)
            $display("FAIL mid_reset_idle got=%b/%0d/%0d exp=0/0/0", busy, done_cnt - d0, cycle_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
